// File: rtl/seg_scan_driver.sv
// Multiplexed hex 7-segment scan driver with guard interval, blanking, leading-zero
// suppression and frame-synchronous double buffering. Define SEG_BLINK_EN to add per-digit blinking.
module seg_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 5000,
  parameter int GUARD_CYC      = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int COM_ACTIVE_LOW = 1,
  parameter int BLINK_DIV      = 5000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  input  logic                    lz_blank,
  input  logic                    load_valid,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   com,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]            SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] COM_OFF  = (COM_ACTIVE_LOW != 0) ? '1 : '0;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("NUM_DIGITS must be 1..16");
  end
  if (SCAN_DIV < 2 || GUARD_CYC < 0 || GUARD_CYC >= SCAN_DIV) begin : g_bad_scan
    $error("SCAN_DIV must be >= 2 and GUARD_CYC in 0..SCAN_DIV-1");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink
    $error("BLINK_DIV must be >= 1");
  end

  logic [CNT_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] act_digits, pend_digits;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp;
  logic [NUM_DIGITS-1:0]   act_blank, pend_blank;
  logic                    pend_flag;
  logic                    tick, boundary;
  logic [NUM_DIGITS-1:0]   blink_dark;

  assign tick       = (div_cnt == LAST_CNT);
  assign boundary   = tick && (idx == LAST_IDX);
  assign frame_done = boundary && !reset;

  // load_valid is a one-way strobe (no ready): every cycle it is high, the presented
  // load/dp_in/blank_mask are taken; a strobe on the frame boundary bypasses pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      idx         <= '0;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '0;
      pend_flag   <= 1'b0;
    end else begin
      if (tick) begin
        div_cnt <= '0;
        idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (boundary) begin
        if (load_valid) begin
          act_digits <= load;
          act_dp     <= dp_in;
          act_blank  <= blank_mask;
        end else if (pend_flag) begin
          act_digits <= pend_digits;
          act_dp     <= pend_dp;
          act_blank  <= pend_blank;
        end
        pend_flag <= 1'b0;
      end else if (load_valid) begin
        pend_digits <= load;
        pend_dp     <= dp_in;
        pend_blank  <= blank_mask;
        pend_flag   <= 1'b1;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] LAST_BLINK = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0]    blink_cnt;
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] act_blink, pend_blink;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      act_blink   <= '0;
      pend_blink  <= '0;
    end else begin
      if (blink_cnt == LAST_BLINK) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if (boundary) begin
        if (load_valid)     act_blink <= blink_mask;
        else if (pend_flag) act_blink <= pend_blink;
      end else if (load_valid) begin
        pend_blink <= blink_mask;
      end
    end
  end

  assign blink_dark = blink_phase ? act_blink : '0;
`else
  assign blink_dark = '0;
`endif

  function automatic logic [6:0] hex_font(input logic [3:0] h);
    case (h)
      4'h0: hex_font = 7'h3F;
      4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;
      4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;
      4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;
      4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;
      4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;
      4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;
      4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;
      default: hex_font = 7'h71;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0] lz_dark, com_on, com_n;
  logic [3:0]            cur_digit;
  logic                  cur_dp, cur_dark, run_zero, guard;
  logic [6:0]            seg_lit, seg_n;
  logic                  dp_n;

  always_comb begin
    lz_dark   = '0;
    com_on    = '0;
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    cur_dark  = 1'b0;
    run_zero  = 1'b1;
    guard     = int'(div_cnt) < GUARD_CYC;
    // Walk from the leftmost digit: a digit is a leading zero while everything left of it is zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero   = run_zero && (act_digits[4*i +: 4] == 4'h0);
      lz_dark[i] = lz_blank && (i > 0) && run_zero;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        cur_digit = act_digits[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_dark  = act_blank[i] || lz_dark[i] || blink_dark[i];
        com_on[i] = !guard;
      end
    end
    seg_lit = cur_dark ? 7'h00 : hex_font(cur_digit);
    seg_n   = (SEG_ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
    dp_n    = (SEG_ACTIVE_LOW != 0) ? !(cur_dp && !cur_dark) : (cur_dp && !cur_dark);
    com_n   = (COM_ACTIVE_LOW != 0) ? ~com_on : com_on;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= SEG_OFF;
      dp  <= DP_OFF;
      com <= COM_OFF;
    end else begin
      seg <= seg_n;
      dp  <= dp_n;
      com <= com_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4 digits, 4-cycle slots, 1 guard cycle, active-low pins.
// With SEG_BLINK_EN defined the blink path is exercised as well.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] load = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        lz_blank = 1'b0;
  logic        load_valid = 1'b0;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  com;
  logic        frame_done;

  int          vectors = 0;
  int          miscompares = 0;
  logic [12:0] exp_q[$];

  // clock/reset block: reset is driven from the stimulus sequence
  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYC(1),
    .SEG_ACTIVE_LOW(1), .COM_ACTIVE_LOW(1), .BLINK_DIV(32)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .dp_in(dp_in), .blank_mask(blank_mask),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .lz_blank(lz_blank), .load_valid(load_valid),
    .seg(seg), .dp(dp), .com(com), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one-cycle strobe presented at a falling edge
  task automatic strobe(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bm);
    load = v; dp_in = dpv; blank_mask = bm; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) chk({tag, "_fd_timeout"}, 16'd0, 16'd1);
  endtask

  // Called at the falling edge where frame_done is high; checks the next frame on the pins.
  // s0..s3 are expected active-low segment codes, dpins the expected dp pin per digit.
  task automatic verify_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpins);
    logic [6:0] sg[4];
    logic [3:0] one;
    logic [3:0] com_e;
    logic [12:0] e;
    sg[0] = s0; sg[1] = s1; sg[2] = s2; sg[3] = s3;
    one = 4'b0001;
    for (int slot = 0; slot < 4; slot++) begin
      for (int c = 0; c < 4; c++) begin
        com_e = (c == 0) ? 4'hF : ~(one << slot);
        exp_q.push_back({(slot == 3 && c == 2), com_e, sg[slot], dpins[slot]});
      end
    end
    @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s_c%0d", tag, j), 16'({frame_done, com, seg, dp}), 16'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset held for three cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_pins", 16'({frame_done, com, seg, dp}), 16'({1'b0, 4'hF, 7'h7F, 1'b1}));
    end
    reset = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      chk($sformatf("first_fd_%0d", k), 16'(frame_done), 16'(k == 15));
      if (k == 1) chk("first_guard", 16'({com, seg, dp}), 16'({4'hF, 7'h40, 1'b1}));
      if (k == 2) chk("first_d0",    16'({com, seg, dp}), 16'({4'hE, 7'h40, 1'b1}));
    end

    // mid-frame load holds until the boundary
    repeat (5) @(negedge clk);
    strobe(16'h1234, 4'h0, 4'h0);
    chk("hold_old", 16'(seg), 16'(7'h40));
    wait_fd("t2");
    verify_frame("f1234", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF);

    // last strobe in a frame wins
    strobe(16'hABCD, 4'h0, 4'h0);
    strobe(16'h5678, 4'h0, 4'h0);
    wait_fd("t3a");
    verify_frame("f5678", 7'h00, 7'h78, 7'h02, 7'h12, 4'hF);

    // strobe coinciding with frame_done goes straight to the active buffer
    wait_fd("t3b");
    load = 16'hABCD; load_valid = 1'b1;
    @(posedge clk);
    #1 load_valid = 1'b0;
    verify_frame("fABCD", 7'h21, 7'h46, 7'h03, 7'h08, 4'hF);

    // leading-zero suppression
    lz_blank = 1'b1;
    strobe(16'h0050, 4'h0, 4'h0);
    wait_fd("t4a");
    verify_frame("lz0050", 7'h40, 7'h12, 7'h7F, 7'h7F, 4'hF);
    strobe(16'h0000, 4'h0, 4'h0);
    wait_fd("t4b");
    verify_frame("lz0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    lz_blank = 1'b0;

    // blank mask and decimal points
    strobe(16'h1234, 4'b0001, 4'b0100);
    wait_fd("t5a");
    verify_frame("blank_dp1", 7'h19, 7'h30, 7'h7F, 7'h79, 4'b1110);
    strobe(16'h1234, 4'b1111, 4'b0100);
    wait_fd("t5b");
    verify_frame("blank_dpall", 7'h19, 7'h30, 7'h7F, 7'h79, 4'b0100);

    // reset mid-frame discards pending data
    strobe(16'h9999, 4'h0, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_pins", 16'({frame_done, com, seg, dp}), 16'({1'b0, 4'hF, 7'h7F, 1'b1}));
    end
    reset = 1'b0;
    wait_fd("t7");
    verify_frame("after_rst", 7'h40, 7'h40, 7'h40, 7'h40, 4'hF);

`ifdef SEG_BLINK_EN
    // blink: phase flips every 32 cycles counted from reset release
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    load = 16'h1234; dp_in = 4'h0; blank_mask = 4'h0; blink_mask = 4'b1000; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    wait_fd("t6a");
    verify_frame("blink_lit0", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF);
    wait_fd("t6b");
    verify_frame("blink_dark", 7'h19, 7'h30, 7'h24, 7'h7F, 4'hF);
    wait_fd("t6c");
    verify_frame("blink_lit1", 7'h19, 7'h30, 7'h24, 7'h79, 4'hF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
